main_memory_controller: RTL and testbench

Memory-side responder for the cache controller's block-transfer interface. Accepts one 4-byte block read or write request per handshake on the memory bus: `addr_mem`, `read_mem_enable`/`write_mem_enable`, `ready_memory`. Services each request after a fixed, parameterised access latency against an internal block-organised array. Returns read data with a one-cycle response strobe. It models and replaces the main-memory end of the cache miss and write-back paths.

---
 rtl/main_memory_controller_pkg.sv | 21 ++
 rtl/main_memory_controller_if.sv | 33 +++
 rtl/main_memory_controller_mem_block_array.sv | 27 ++
 rtl/main_memory_controller.sv | 133 +++++++++++++
 tb/tb_main_memory_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_controller_pkg.sv
// Shared definitions for the main-memory responder and its cache-side peer:
// FSM encoding, block geometry and the block-index slice position.
package main_memory_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam int MEM_DATAWIDTH = 8;
  localparam int MEM_BLOCKSIZE = 4;
  localparam int MEM_BW        = MEM_DATAWIDTH * MEM_BLOCKSIZE;

  // Byte-offset bits inside a block; the block index starts right above them.
  localparam int BLK_IDX_LSB   = 2;

  // Latency counter width; holds LATENCY-2 for LATENCY up to 15.
  localparam int CNT_W         = 4;

endpackage

// File: rtl/main_memory_controller_if.sv
// Block-transfer bus between the cache controller (master) and main memory
// (slave).
//
// Handshake: a request is accepted on a rising edge where ready_memory=1 and
// read_mem_enable or write_mem_enable is high; addr_mem and write_mem_data
// are sampled on that edge. Enables are levels: after an accept the slave
// ignores them until it has seen both low on some edge. Completion of every
// accepted request (read or write) is signalled by a one-cycle resp_valid;
// read_mem_data is valid in that cycle and held afterwards.
interface main_memory_controller_if #(
  parameter int AWIDTH = 16,
  parameter int BW     = 32
) ();

  logic [AWIDTH-1:0] addr_mem;
  logic              read_mem_enable;
  logic              write_mem_enable;
  logic [BW-1:0]     write_mem_data;
  logic [BW-1:0]     read_mem_data;
  logic              resp_valid;
  logic              ready_memory;

  modport master (
    output addr_mem, read_mem_enable, write_mem_enable, write_mem_data,
    input  read_mem_data, resp_valid, ready_memory
  );

  modport slave (
    input  addr_mem, read_mem_enable, write_mem_enable, write_mem_data,
    output read_mem_data, resp_valid, ready_memory
  );

endinterface

// File: rtl/main_memory_controller_mem_block_array.sv
// Block-organised storage: one BW-bit word per block, synchronous write and
// registered synchronous read. Contents are never reset.
module mem_block_array #(
  parameter int BAWIDTH = 8,
  parameter int BW      = 32
) (
  input  logic               clock,
  input  logic               we,
  input  logic               re,
  input  logic [BAWIDTH-1:0] addr,
  input  logic [BW-1:0]      wdata,
  output logic [BW-1:0]      rdata
);

  logic [BW-1:0] mem [2**BAWIDTH];

  // Write commits and read data registers on the same edge, no reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/main_memory_controller.sv
// Main-memory responder for cache block transfers. Accepts one block read or
// write per handshake, waits a fixed LATENCY, accesses the array and pulses
// resp_valid for one cycle. A level enable held across a completed request
// does not retrigger: the controller re-arms only after both enables are low.
module main_memory_controller
  import main_memory_controller_pkg::*;
#(
  parameter int AWIDTH    = 16,
  parameter int DATAWIDTH = MEM_DATAWIDTH,
  parameter int BLOCKSIZE = MEM_BLOCKSIZE,
  parameter int BAWIDTH   = 8,
  parameter int LATENCY   = 4   // legal range 2..15
) (
  input  logic                            clock,
  input  logic                            reset,
  main_memory_controller_if.slave         mem_bus,
  output state_t                          state_dbg
);

  localparam int BW = DATAWIDTH * BLOCKSIZE;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               armed_q;
  logic               op_write_q;
  logic [BAWIDTH-1:0] idx_q;
  logic [BW-1:0]      wdata_q;
  logic               read_loaded_q;
  logic [BW-1:0]      array_rdata;

  logic accept;
  logic access;
  logic array_we;
  logic array_re;
  logic enables_low;

  // Byte-offset bits and bits above the block index are intentionally dropped,
  // so addresses alias modulo 2^BAWIDTH blocks.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_bus.addr_mem[AWIDTH-1:BAWIDTH+BLK_IDX_LSB],
                              mem_bus.addr_mem[BLK_IDX_LSB-1:0]};

  assign enables_low = !mem_bus.read_mem_enable && !mem_bus.write_mem_enable;
  assign accept      = (state_q == ST_IDLE) && armed_q && !enables_low;
  assign access      = (state_q == ST_BUSY) && (cnt_q == '0);
  assign array_we    = access && op_write_q;
  assign array_re    = access && !op_write_q;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: IDLE -> BUSY on accept, BUSY -> RESPOND at count 0,
  // RESPOND lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_BUSY;
      ST_BUSY:    if (cnt_q == '0) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Latency counter: loaded at accept, counts down while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Re-arm flag: cleared by an accept, set by any edge with both enables low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b1;
    end else if (accept) begin
      armed_q <= 1'b0;
    end else if (enables_low) begin
      armed_q <= 1'b1;
    end
  end

  // Request latches; write wins when both enables are high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      op_write_q <= mem_bus.write_mem_enable;
      idx_q      <= mem_bus.addr_mem[BLK_IDX_LSB +: BAWIDTH];
      wdata_q    <= mem_bus.write_mem_data;
    end
  end

  // Marks that the array's read register holds a real read since reset; the
  // array itself has no reset, so read_mem_data is forced to zero until then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_loaded_q <= 1'b0;
    end else if (array_re) begin
      read_loaded_q <= 1'b1;
    end
  end

  mem_block_array #(
    .BAWIDTH (BAWIDTH),
    .BW      (BW)
  ) u_array (
    .clock (clock),
    .we    (array_we),
    .re    (array_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (array_rdata)
  );

  assign mem_bus.ready_memory  = (state_q == ST_IDLE) && armed_q;
  assign mem_bus.resp_valid    = (state_q == ST_RESPOND);
  assign mem_bus.read_mem_data = read_loaded_q ? array_rdata : '0;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_main_memory_controller.sv
// Bench for main_memory_controller: directed vector table, hand-written
// sequences for held-enable and mid-write reset, then random traffic checked
// against a block-indexed associative-array memory model.
module tb_main_memory_controller;
  import main_memory_controller_pkg::*;

  localparam int LAT = 4;
  localparam int BAW = 8;

  logic   clock;
  logic   reset;
  state_t state_dbg;

  main_memory_controller_if #(.AWIDTH(16), .BW(32)) bus ();

  main_memory_controller #(
    .AWIDTH(16), .DATAWIDTH(8), .BLOCKSIZE(4), .BAWIDTH(BAW), .LATENCY(LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_bus   (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];
  int last_accept = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int blk(input logic [15:0] a);
    return int'(a[BAW+1:2]);
  endfunction

  // ---------------- driver ----------------
  // One complete request: wait for ready, present it for the accept edge,
  // drop the enables, then check latency, data and the one-cycle strobe.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] data, input bit chk_data, input string name);
    int cyc;
    bit seen;
    logic [31:0] exp_data;
    cyc = 0;
    while (!bus.ready_memory && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (!bus.ready_memory) begin
      check({name, "_ready_timeout"}, 32'(bus.ready_memory), 32'd1);
      return;
    end
    bus.addr_mem         = addr;
    bus.read_mem_enable  = rd;
    bus.write_mem_enable = wr;
    bus.write_mem_data   = data;
    @(negedge clock);
    check({name, "_spacing_ok"}, 32'((cycle_cnt - last_accept) >= LAT + 1), 32'd1);
    last_accept = cycle_cnt;
    check({name, "_ready_low"}, 32'(bus.ready_memory), 32'd0);
    bus.read_mem_enable  = 1'b0;
    bus.write_mem_enable = 1'b0;
    bus.addr_mem         = 16'($urandom);
    bus.write_mem_data   = $urandom;
    if (wr) model_mem[blk(addr)] = data;
    else if (chk_data) exp_q.push_back(model_mem[blk(addr)]);
    cyc = 1;
    seen = bus.resp_valid;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      seen = bus.resp_valid;
    end
    check({name, "_latency"}, 32'(cyc), 32'(LAT));
    if (seen && !wr && chk_data) begin
      exp_data = exp_q.pop_front();
      check({name, "_rdata"}, bus.read_mem_data, exp_data);
    end
    @(negedge clock);
    check({name, "_strobe_one_cycle"}, 32'(bus.resp_valid), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    bit          chk;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int resp_cnt;
    bit ready_stayed_low;
    logic [15:0] ra;
    logic        rrd, rwr;

    reset = 1'b0;
    bus.addr_mem = '0;
    bus.read_mem_enable = 1'b0;
    bus.write_mem_enable = 1'b0;
    bus.write_mem_data = '0;

    vecs[0] = '{1'b0, 1'b1, 16'h0040, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0041, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 16'h0100, 32'h12345678, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0100, 32'h0,        32'h12345678, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'h0200, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0200, 32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h0400, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'h0103, 32'h0,        32'h12345678, 1'b1};

    repeat (3) @(negedge clock);
    check("rst_ready", 32'(bus.ready_memory), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.read_mem_data, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b1;
    @(negedge clock);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0,
             $sformatf("vec%0d", i));
      if (vecs[i].chk) check($sformatf("vec%0d_table_rdata", i), bus.read_mem_data,
                             vecs[i].exp_rdata);
    end

    // Held read enable: exactly one response, no re-arm while held.
    while (!bus.ready_memory) @(negedge clock);
    bus.addr_mem = 16'h0040;
    bus.read_mem_enable = 1'b1;
    resp_cnt = 0;
    ready_stayed_low = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        resp_cnt++;
        check("held_rdata", bus.read_mem_data, 32'hDEADBEEF);
      end
      if (bus.ready_memory) ready_stayed_low = 1'b0;
    end
    check("held_resp_count", 32'(resp_cnt), 32'd1);
    check("held_ready_low", 32'(ready_stayed_low), 32'd1);
    bus.read_mem_enable = 1'b0;
    @(negedge clock);
    check("held_rearm_ready", 32'(bus.ready_memory), 32'd1);
    last_accept = -100;

    // Reset during a write: the write is lost, old data survives.
    do_txn(1'b0, 1'b1, 16'h0080, 32'h22222222, 1'b0, "pre_rst_wr");
    while (!bus.ready_memory) @(negedge clock);
    bus.addr_mem = 16'h0080;
    bus.write_mem_data = 32'h11111111;
    bus.write_mem_enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.write_mem_enable = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready_memory), 32'd1);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_rdata", bus.read_mem_data, 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b1;
    last_accept = -100;
    do_txn(1'b1, 1'b0, 16'h0080, 32'h0, 1'b1, "post_rst_rd");
    check("post_rst_value", bus.read_mem_data, 32'h22222222);

    // Random traffic against the memory model.
    for (int n = 0; n < 60; n++) begin
      ra = {6'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
      case ($urandom_range(0, 2))
        0: begin rrd = 1'b1; rwr = 1'b0; end
        1: begin rrd = 1'b0; rwr = 1'b1; end
        default: begin rrd = 1'b1; rwr = 1'b1; end
      endcase
      do_txn(rrd, rwr, ra, $urandom, !rwr && model_mem.exists(blk(ra)),
             $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
